i2c_byte_sequencer: RTL and testbench
=====================================

# i2c_byte_sequencer

Byte-level command sequencer sitting directly upstream of `i2c_master_bit_ctrl`. It accepts byte commands (START/WRITE/READ/STOP combinations plus an 8-bit payload) from the register/host side. It breaks each command into the bit-level commands START, WRITE, READ and STOP, issues them to the bit controller, and handshakes on the bit controller's `cmd_ack`. It returns received data, the slave/master ACK bit, and arbitration-loss status to the host.

## Interface
- `DW`, 8, byte width; only 8 is supported; sizes the shift register and the `din`/`dout` ports.
- `clk` in 1: system clock; all logic is on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: generate START before the byte transfer.
- `stop` in 1: generate STOP after the byte transfer, or alone.
- `read` in 1: read one byte.
- `write` in 1: write one byte.
- `ack_in` in 1: ACK bit the master sends after a read (0 = ACK, 1 = NACK).
- `din` in DW: byte to write.
- `cmd_ack` out 1: one-cycle pulse when the whole byte command completes.
- `ack_out` out 1: ACK bit sampled from the slave after a write.
- `dout` out DW: received byte; valid when `cmd_ack` is high.
- `i2c_al` out 1: one-cycle arbitration-loss pulse.
- `core_cmd` out 4: bit command to the bit controller.
- `core_txd` out 1: bit value for a bit-controller WRITE.
- `core_ack` in 1: bit-controller command acknowledge.
- `core_rxd` in 1: bit-controller read bit, valid with `core_ack`.
- `core_al` in 1: bit-controller arbitration lost.

## Operation
- Host protocol:
  - Host asserts any of `start`, `stop`, `read`, `write` and holds them until `cmd_ack`.
  - Host must deassert them in the cycle after `cmd_ack`.
  - `read` and `write` together is illegal; `write` wins.
- Go condition: `go = (start|stop|read|write) & ~cmd_ack`. It is sampled only in IDLE.
- Bit command codes: NOP=0000, START=0001, STOP=0010, WRITE=0100, READ=1000.
- States are IDLE, START, WRITE, READ, ACK, STOP.
- IDLE on `go`:
  - Load the shift register with `din` and set the bit counter to 7.
  - Next state is the first applicable of START, then WRITE, then READ, then STOP.
  - Drive the matching `core_cmd` on the same edge.
- START on `core_ack`: go to WRITE, READ or STOP (same priority as IDLE). If none is requested, go to IDLE and pulse `cmd_ack`.
- WRITE:
  - `core_txd` = shift-register MSB.
  - Each `core_ack` shifts left one bit and decrements the counter.
  - On `core_ack` with counter = 0, go to ACK with `core_cmd` = READ.
- READ:
  - Each `core_ack` shifts `core_rxd` into the LSB and decrements the counter.
  - On `core_ack` with counter = 0, go to ACK with `core_cmd` = WRITE and `core_txd` = `ack_in`.
- ACK on `core_ack`:
  - After a write, `ack_out` <= `core_rxd`.
  - If `stop`, go to STOP with `core_cmd` = STOP.
  - Otherwise go to IDLE with `core_cmd` = NOP and pulse `cmd_ack`.
- STOP on `core_ack`: go to IDLE, `core_cmd` = NOP, pulse `cmd_ack`.
- `dout` is the shift register, so it is stable from the `cmd_ack` cycle until the next `go`.
- The counter wraps 0 -> 7 only through a reload in IDLE, never by decrement.

## Timing
- Reset values:
  - state IDLE, `core_cmd` = 0000, `core_txd` = 0, `cmd_ack` = 0.
  - `ack_out` = 0, `dout` = 0x00, `i2c_al` = 0, counter = 7.
- All outputs are registered.
- The first `core_cmd` appears one cycle after `go` is sampled.
- On each `core_ack`, the next `core_cmd` is driven on the following edge, so there are no NOP gaps between bits.
- Full START+WRITE+STOP is exactly 11 bit commands. `cmd_ack` is asserted 1 cycle after the final `core_ack`.
- `core_ack` outside an active state (IDLE) is ignored.
- `rst` mid-byte: next edge returns to reset values. The bus is not cleaned up; the host reissues STOP.
- `core_al` coincident with `core_ack`: `core_al` takes priority (see Configuration).

## Configuration
- With `I2C_SEQ_AL_ABORT_EN` defined, `core_al` in any state forces on the next edge:
  - state IDLE, `core_cmd` = NOP;
  - `i2c_al` pulse for 1 cycle;
  - `cmd_ack` pulse for 1 cycle, so the host is released;
  - `dout` and `ack_out` unchanged.
- Without it, `i2c_al` is a registered copy of `core_al` delayed 1 cycle. The FSM ignores `core_al` and continues on `core_ack`.

## Structure
- Shared defines file `i2c_defines.v` holds:
  - bit-command codes I2C_CMD_NOP/START/STOP/WRITE/READ, also used by `i2c_master_bit_ctrl`;
  - sequencer state encodings.
- One sub-module, `i2c_byte_shifter`: DW-bit shift register plus 3-bit down counter, with load/shift/serial-in and a `last` flag at counter = 0.
- The FSM lives in the top module.

## Test plan
- Use a mock bit controller that pulses `core_ack` 4 cycles after each new command.
- START+WRITE, `din` = 0xA5, slave returns `core_rxd` = 0 at ACK:
  - command sequence START, then WRITE with bits 1,0,1,0,0,1,0,1, then READ;
  - then `cmd_ack` with `ack_out` = 0.
- READ with `core_rxd` = 0x3C MSB first, `ack_in` = 1, plus `stop`:
  - 8 READs, then WRITE with `core_txd` = 1, then STOP;
  - `cmd_ack` with `dout` = 0x3C.
- `stop` alone from IDLE: one STOP command, then `cmd_ack` 1 cycle after its `core_ack`.
- `core_al` during bit 3 of a write:
  - with the macro: IDLE next cycle, `i2c_al` and `cmd_ack` pulse;
  - without the macro: the transfer completes all 9 bits.
- `rst` asserted during bit 5 of a read: next cycle all outputs are at reset values. A new WRITE 0x01 then completes normally.
- Host holds `write` one extra cycle after `cmd_ack`: no second transfer starts.

Source files
------------

// File: rtl/i2c_byte_sequencer_pkg.sv
// Shared definitions for the I2C byte sequencer: bit-command codes (common
// with the bit controller), sequencer state encoding and a small helper.
package i2c_byte_sequencer_pkg;

  localparam logic [3:0] I2C_CMD_NOP   = 4'b0000;
  localparam logic [3:0] I2C_CMD_START = 4'b0001;
  localparam logic [3:0] I2C_CMD_STOP  = 4'b0010;
  localparam logic [3:0] I2C_CMD_WRITE = 4'b0100;
  localparam logic [3:0] I2C_CMD_READ  = 4'b1000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_WRITE = 3'd2,
    ST_READ  = 3'd3,
    ST_ACK   = 3'd4,
    ST_STOP  = 3'd5
  } seq_state_e;

  // Data phase selection once any START is done: write beats read, a lone
  // STOP follows, and nothing left means the command is finished.
  function automatic seq_state_e next_data_state(input logic wr, input logic rd, input logic sp);
    seq_state_e ns;
    if (wr) begin
      ns = ST_WRITE;
    end else if (rd) begin
      ns = ST_READ;
    end else if (sp) begin
      ns = ST_STOP;
    end else begin
      ns = ST_IDLE;
    end
    return ns;
  endfunction

endpackage

// File: rtl/i2c_byte_sequencer_shifter.sv
// Byte shift register plus 3-bit down counter for the I2C byte sequencer.
// The counter reloads to 7 on load and holds at 0 (it never wraps by
// decrement); `last` flags the final bit of the byte.
module i2c_byte_sequencer_shifter #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          shift,
  input  logic          sin,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] q,
  output logic          last
);

  logic [DW-1:0] sr_q, sr_d;
  logic [2:0]    cnt_q, cnt_d;

  // Next value of the shift register and bit counter.
  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (load) begin
      sr_d  = din;
      cnt_d = 3'd7;
    end else if (shift) begin
      sr_d = {sr_q[DW-2:0], sin};
      if (cnt_q != 3'd0) begin
        cnt_d = cnt_q - 3'd1;
      end else begin
        cnt_d = cnt_q;
      end
    end else begin
      sr_d  = sr_q;
      cnt_d = cnt_q;
    end
  end

  // Shift register and counter flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q  <= '0;
      cnt_q <= 3'd7;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

  assign q    = sr_q;
  assign last = (cnt_q == 3'd0);

endmodule

// File: rtl/i2c_byte_sequencer.sv
// I2C byte command sequencer: splits host byte commands into bit commands
// for the bit controller and returns data, ACK and arbitration status.
// Optional macro I2C_SEQ_AL_ABORT_EN: arbitration loss aborts the command
// back to IDLE and releases the host with cmd_ack.
module i2c_byte_sequencer
  import i2c_byte_sequencer_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stop,
  input  logic          read,
  input  logic          write,
  input  logic          ack_in,
  input  logic [DW-1:0] din,
  output logic          cmd_ack,
  output logic          ack_out,
  output logic [DW-1:0] dout,
  output logic          i2c_al,
  output logic [3:0]    core_cmd,
  output logic          core_txd,
  input  logic          core_ack,
  input  logic          core_rxd,
  input  logic          core_al
);

  seq_state_e state_q, state_d, state_nat;
  logic [3:0] core_cmd_q, core_cmd_d;
  logic       core_txd_q, core_txd_d;
  logic       cmd_ack_q, cmd_ack_d;
  logic       ack_out_q, ack_out_d;
  logic       i2c_al_q, i2c_al_d;
  logic       go, abort, sr_load, sr_shift, last;
  logic [DW-1:0] sr;

`ifdef I2C_SEQ_AL_ABORT_EN
  assign abort = core_al;
`else
  assign abort = 1'b0;
`endif

  // A new command is only accepted while cmd_ack is not being presented,
  // so a host still holding its request in the ack cycle cannot restart.
  assign go       = (start | stop | read | write) & ~cmd_ack_q;
  assign sr_load  = (state_q == ST_IDLE) & go & ~abort;
  assign sr_shift = core_ack & ((state_q == ST_WRITE) | (state_q == ST_READ)) & ~abort;

  i2c_byte_sequencer_shifter #(.DW(DW)) u_shifter (
    .clk   (clk),
    .rst   (rst),
    .load  (sr_load),
    .shift (sr_shift),
    .sin   (core_rxd),
    .din   (din),
    .q     (sr),
    .last  (last)
  );

  // State and registered-output flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      core_cmd_q <= I2C_CMD_NOP;
      core_txd_q <= 1'b0;
      cmd_ack_q  <= 1'b0;
      ack_out_q  <= 1'b0;
      i2c_al_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      core_cmd_q <= core_cmd_d;
      core_txd_q <= core_txd_d;
      cmd_ack_q  <= cmd_ack_d;
      ack_out_q  <= ack_out_d;
      i2c_al_q   <= i2c_al_d;
    end
  end

  // Next-state logic; an arbitration abort overrides the normal flow.
  always_comb begin
    state_nat = state_q;
    case (state_q)
      ST_IDLE: begin
        if (go) begin
          state_nat = start ? ST_START : next_data_state(write, read, stop);
        end else begin
          state_nat = ST_IDLE;
        end
      end
      ST_START: begin
        if (core_ack) begin
          state_nat = next_data_state(write, read, stop);
        end else begin
          state_nat = ST_START;
        end
      end
      ST_WRITE, ST_READ: begin
        if (core_ack && last) begin
          state_nat = ST_ACK;
        end else begin
          state_nat = state_q;
        end
      end
      ST_ACK: begin
        if (core_ack) begin
          state_nat = stop ? ST_STOP : ST_IDLE;
        end else begin
          state_nat = ST_ACK;
        end
      end
      ST_STOP: begin
        if (core_ack) begin
          state_nat = ST_IDLE;
        end else begin
          state_nat = ST_STOP;
        end
      end
      default: state_nat = ST_IDLE;
    endcase
    state_d = abort ? ST_IDLE : state_nat;
  end

  // Registered outputs follow the state being entered, so each bit command
  // is on the bus the edge after the previous acknowledge.
  always_comb begin
    case (state_d)
      ST_IDLE:  core_cmd_d = I2C_CMD_NOP;
      ST_START: core_cmd_d = I2C_CMD_START;
      ST_WRITE: core_cmd_d = I2C_CMD_WRITE;
      ST_READ:  core_cmd_d = I2C_CMD_READ;
      ST_ACK:   core_cmd_d = write ? I2C_CMD_READ : I2C_CMD_WRITE;
      ST_STOP:  core_cmd_d = I2C_CMD_STOP;
      default:  core_cmd_d = I2C_CMD_NOP;
    endcase

    // The transmit bit is presented together with its WRITE command.
    if ((state_q == ST_IDLE) && (state_d == ST_WRITE)) begin
      core_txd_d = din[DW-1];
    end else if ((state_q == ST_START) && (state_d == ST_WRITE)) begin
      core_txd_d = sr[DW-1];
    end else if ((state_q == ST_WRITE) && (state_d == ST_WRITE) && core_ack) begin
      core_txd_d = sr[DW-2];
    end else if ((state_q == ST_READ) && (state_d == ST_ACK)) begin
      core_txd_d = ack_in;
    end else begin
      core_txd_d = core_txd_q;
    end

    cmd_ack_d = abort | ((state_q != ST_IDLE) & (state_d == ST_IDLE));

    if ((state_q == ST_ACK) && core_ack && write && !abort) begin
      ack_out_d = core_rxd;
    end else begin
      ack_out_d = ack_out_q;
    end

    i2c_al_d = core_al;
  end

  assign core_cmd = core_cmd_q;
  assign core_txd = core_txd_q;
  assign cmd_ack  = cmd_ack_q;
  assign ack_out  = ack_out_q;
  assign i2c_al   = i2c_al_q;
  assign dout     = sr;

endmodule

// File: tb/tb_i2c_byte_sequencer.sv
// Scoreboard bench for i2c_byte_sequencer with a mock bit controller that
// acknowledges each bit command 4 cycles after it appears.
module tb_i2c_byte_sequencer;
  import i2c_byte_sequencer_pkg::*;

  logic       clk = 1'b0;
  logic       rst, start, stop, read, write, ack_in;
  logic [7:0] din;
  logic       cmd_ack, ack_out, i2c_al;
  logic [7:0] dout;
  logic [3:0] core_cmd;
  logic       core_txd, core_ack, core_rxd, core_al;

  i2c_byte_sequencer #(.DW(8)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .read(read), .write(write),
    .ack_in(ack_in), .din(din), .cmd_ack(cmd_ack), .ack_out(ack_out), .dout(dout),
    .i2c_al(i2c_al), .core_cmd(core_cmd), .core_txd(core_txd), .core_ack(core_ack),
    .core_rxd(core_rxd), .core_al(core_al)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

`ifdef I2C_SEQ_AL_ABORT_EN
  localparam bit ABORT_EN = 1'b1;
`else
  localparam bit ABORT_EN = 1'b0;
`endif

  typedef struct { logic [3:0] cmd; logic txd; logic txd_care; } bit_t;
  typedef struct { int nbits; logic chk_dout; logic [7:0] dout; logic ack_out; logic abort; } res_t;

  bit_t exp_bits[$];
  res_t exp_res[$];
  logic rxd_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  logic model_ack_out = 1'b0;

  // mock bit-controller state
  bit mk_busy = 0;
  int mk_wait = 0, mk_wr_cnt = 0, mk_rd_cnt = 0, last_ack_cyc = 0, al_cyc = 0;
  bit al_req = 0;
  // monitor state
  int   mon_bits = 0;
  logic al_prev = 1'b0;

  function void check(string name, logic [31:0] act, logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  // Mock bit controller: acks each new command after 4 cycles, supplies read bits.
  initial begin
    core_ack = 1'b0; core_rxd = 1'b0; core_al = 1'b0;
    forever begin
      @(posedge clk); #1;
      core_ack = 1'b0;
      core_al  = 1'b0;
      if (cmd_ack) begin mk_wr_cnt = 0; mk_rd_cnt = 0; end
      if (!mk_busy && core_cmd != I2C_CMD_NOP) begin mk_busy = 1; mk_wait = 0; end
      if (mk_busy) begin
        if (core_cmd == I2C_CMD_NOP) mk_busy = 0;
        else begin
          mk_wait++;
          if (al_req && core_cmd == I2C_CMD_WRITE && mk_wr_cnt == 3 && mk_wait == 2) begin
            core_al = 1'b1; al_req = 0; al_cyc = cyc;
          end
          if (mk_wait == 4) begin
            core_ack = 1'b1; mk_wait = 0; last_ack_cyc = cyc;
            if (core_cmd == I2C_CMD_READ) begin
              core_rxd = (rxd_q.size() > 0) ? rxd_q.pop_front() : 1'b0;
              mk_rd_cnt++;
            end else begin
              core_rxd = 1'($urandom);
            end
            if (core_cmd == I2C_CMD_WRITE) mk_wr_cnt++;
          end
        end
      end
    end
  end

  // Monitor: compares each acknowledged bit and each completed byte command.
  initial begin
    bit_t e;
    res_t r;
    forever begin
      @(posedge clk); #2;
      check("i2c_al", i2c_al, al_prev);
      al_prev = core_al;
      if (core_ack) begin
        mon_bits++;
        if (exp_bits.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_bit: got cmd %b expected none (cycle %0d)", core_cmd, cyc);
        end else begin
          e = exp_bits.pop_front();
          check("bit_cmd", core_cmd, e.cmd);
          if (e.txd_care) check("bit_txd", core_txd, e.txd);
        end
      end
      if (cmd_ack) begin
        if (exp_res.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_cmd_ack: got cmd_ack 1 expected 0 (cycle %0d)", cyc);
        end else begin
          r = exp_res.pop_front();
          check("nbits", mon_bits, r.nbits);
          check("ack_out", ack_out, r.ack_out);
          if (r.chk_dout) check("dout", dout, r.dout);
          if (r.abort) check("abort_latency", cyc, al_cyc + 1);
          else check("cmd_ack_latency", cyc, last_ack_cyc + 1);
        end
        mon_bits = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #3;
  endtask

  // Reference model: expands a byte command into its bit-command list.
  task automatic plan(input bit st, sp, rd, wr, input logic [7:0] dn, input logic ai,
                      input logic [7:0] sbyte, input logic sack, input bit al);
    bit_t lst[$];
    res_t r;
    bit   abort_x = ABORT_EN && al && wr;
    int   keep;
    if (st) lst.push_back('{I2C_CMD_START, 1'b0, 1'b0});
    if (wr) begin
      for (int i = 7; i >= 0; i--) lst.push_back('{I2C_CMD_WRITE, dn[i], 1'b1});
      lst.push_back('{I2C_CMD_READ, 1'b0, 1'b0});
      if (!abort_x) begin rxd_q.push_back(sack); model_ack_out = sack; end
    end else if (rd) begin
      for (int i = 7; i >= 0; i--) begin
        lst.push_back('{I2C_CMD_READ, 1'b0, 1'b0});
        rxd_q.push_back(sbyte[i]);
      end
      lst.push_back('{I2C_CMD_WRITE, ai, 1'b1});
    end
    if (sp) lst.push_back('{I2C_CMD_STOP, 1'b0, 1'b0});
    keep = abort_x ? (int'(st) + 3) : lst.size();
    for (int i = 0; i < keep; i++) exp_bits.push_back(lst[i]);
    r.nbits = keep; r.chk_dout = rd && !wr && !abort_x; r.dout = sbyte;
    r.ack_out = model_ack_out; r.abort = abort_x;
    exp_res.push_back(r);
  endtask

  task automatic launch(input bit st, sp, rd, wr, input logic [7:0] dn, input logic ai,
                        input logic [7:0] sbyte, input logic sack, input bit al);
    logic [3:0] first;
    plan(st, sp, rd, wr, dn, ai, sbyte, sack, al);
    first = exp_bits[0].cmd;
    al_req = al;
    start = st; stop = sp; read = rd; write = wr; din = dn; ack_in = ai;
    tick();
    check("first_cmd", core_cmd, first);
  endtask

  task automatic run_xfer(input bit st, sp, rd, wr, input logic [7:0] dn, input logic ai,
                          input logic [7:0] sbyte, input logic sack, input bit al, input bit hold);
    int t = 0;
    launch(st, sp, rd, wr, dn, ai, sbyte, sack, al);
    while (!cmd_ack && t < 3000) begin tick(); t++; end
    if (!cmd_ack) begin
      n_checks++; n_fail++;
      $display("FAIL cmd_ack_timeout: got no cmd_ack expected one within 3000 cycles");
    end
    if (hold) tick();
    start = 0; stop = 0; read = 0; write = 0;
    if (hold) begin
      for (int i = 0; i < 8; i++) begin tick(); check("no_restart", core_cmd, I2C_CMD_NOP); end
    end else begin
      tick(); tick();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got simulation still running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    rst = 1'b1; start = 0; stop = 0; read = 0; write = 0; ack_in = 0; din = 8'h00;
    repeat (3) tick();
    check("rst_core_cmd", core_cmd, 4'b0000);
    check("rst_core_txd", core_txd, 1'b0);
    check("rst_cmd_ack", cmd_ack, 1'b0);
    check("rst_ack_out", ack_out, 1'b0);
    check("rst_dout", dout, 8'h00);
    check("rst_i2c_al", i2c_al, 1'b0);
    rst = 1'b0;
    tick();

    // START+WRITE with slave NACK, then START+WRITE 0xA5 with slave ACK
    run_xfer(1, 0, 0, 1, 8'h5A, 0, 8'h00, 1'b1, 0, 0);
    run_xfer(1, 0, 0, 1, 8'hA5, 0, 8'h00, 1'b0, 0, 0);
    // READ 0x3C, master NACK, then STOP
    run_xfer(0, 1, 1, 0, 8'h00, 1, 8'h3C, 1'b0, 0, 0);
    // STOP alone, START alone, read+write together (write wins)
    run_xfer(0, 1, 0, 0, 8'h00, 0, 8'h00, 1'b0, 0, 0);
    run_xfer(1, 0, 0, 0, 8'h00, 0, 8'h00, 1'b0, 0, 0);
    run_xfer(0, 0, 1, 1, 8'hC3, 0, 8'hFF, 1'b1, 0, 0);
    // arbitration loss during write bit 3
    run_xfer(1, 1, 0, 1, 8'h96, 0, 8'h00, 1'b0, 1, 0);
    // host holds write one extra cycle after cmd_ack
    run_xfer(0, 0, 0, 1, 8'h81, 0, 8'h00, 1'b1, 0, 1);

    // reset during bit 5 of a read
    launch(0, 1, 1, 0, 8'h00, 0, 8'hB7, 1'b0, 0);
    t = 0;
    while (mk_rd_cnt < 5 && t < 500) begin tick(); t++; end
    check("rd_progress", mk_rd_cnt, 5);
    tick(); tick();
    rst = 1'b1; start = 0; stop = 0; read = 0; write = 0;
    tick();
    exp_bits.delete(); exp_res.delete(); rxd_q.delete();
    mon_bits = 0; mk_rd_cnt = 0; mk_wr_cnt = 0; model_ack_out = 1'b0;
    check("mid_rst_core_cmd", core_cmd, 4'b0000);
    check("mid_rst_core_txd", core_txd, 1'b0);
    check("mid_rst_cmd_ack", cmd_ack, 1'b0);
    check("mid_rst_ack_out", ack_out, 1'b0);
    check("mid_rst_dout", dout, 8'h00);
    check("mid_rst_i2c_al", i2c_al, 1'b0);
    rst = 1'b0;
    tick(); tick();
    run_xfer(0, 0, 0, 1, 8'h01, 0, 8'h00, 1'b0, 0, 0);

    // randomized byte commands
    for (int n = 0; n < 40; n++) begin
      bit st, sp, rd, wr;
      st = 1'($urandom); sp = 1'($urandom); rd = 1'($urandom); wr = 1'($urandom);
      if (!(st | sp | rd | wr)) sp = 1;
      run_xfer(st, sp, rd, wr, 8'($urandom), 1'($urandom), 8'($urandom), 1'($urandom), 0, 0);
    end

    repeat (4) tick();
    check("leftover_bits", exp_bits.size(), 0);
    check("leftover_results", exp_res.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
